fp_mult_param: RTL and testbench
================================

FP_MULT_PARAM -- requirements
Module: fp_mult_param

Interface
REQ-001 SHALL provide parameter EXP_W, default 5, exponent field width (range 4..8).
REQ-002 SHALL provide parameter MAN_W, default 10, stored mantissa width (range 3..23).
REQ-003 SHALL derive W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1; neither is an overridable parameter.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand pair a/b is valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-008 SHALL have port a  input  W  operand A as {sign, exp, mantissa}.
REQ-009 SHALL have port b  input  W  operand B, same format as a.
REQ-010 SHALL have port out_valid  output  1  result and flags are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  W  product, same format as a.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-014 SHALL implement FSM states IDLE, MULT, NORM, ROUND, DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-015 SHALL capture a and b on the edge where in_valid & in_ready, and move IDLE->MULT on that edge; in_valid without in_ready SHALL be ignored.
REQ-016 SHALL transition MULT->NORM->ROUND->DONE unconditionally, one state per cycle; with capture at edge 0, out_valid SHALL be high after edge 3.
REQ-017 SHALL hold result and flags stable in DONE while out_ready = 0, and move DONE->IDLE on the edge where out_ready = 1; the next pair can be accepted one cycle later.
REQ-018 SHALL form sign = sign_a XOR sign_b for every result, including zero and inf; canonical NaN has sign 0.
REQ-019 SHALL compute the significand product of {1, man_a} and {1, man_b} as an exact 2*(MAN_W+1)-bit unsigned value in MULT.
REQ-020 SHALL compute the exponent as exp_a + exp_b - BIAS in a signed (EXP_W+2)-bit intermediate, with no wrap-around.
REQ-021 SHALL, in NORM, when the product MSB is 1, shift right by 1 and increment the exponent.
REQ-022 SHALL, in NORM, extract the MAN_W mantissa bits, guard bit, round bit, and sticky (OR of all remaining lower bits).
REQ-023 SHALL round to nearest, ties to even, in ROUND: increment when guard & (round | sticky | lsb).
REQ-024 SHALL, when rounding carries out of the mantissa, renormalise (mantissa = 0, exponent + 1).
REQ-025 SHALL set inexact whenever guard | round | sticky = 1.
REQ-026 SHALL, when the final exponent >= 2^EXP_W-1, output signed infinity and set overflow and inexact.
REQ-027 SHALL, when the final exponent <= 0, flush to signed zero and set underflow and inexact; subnormal results are never produced.
REQ-028 SHALL treat subnormal inputs (exp = 0, mantissa != 0) as signed zero, with no flag raised for that reason alone.
REQ-029 SHALL apply special-case precedence, highest first: any NaN input -> canonical qNaN (exp all ones, mantissa MSB 1, rest 0), invalid = 0.
REQ-030 SHALL apply, next in precedence: inf x zero -> canonical qNaN, invalid = 1.
REQ-031 SHALL apply, next in precedence: inf x finite -> signed inf, no flags.
REQ-032 SHALL apply, next in precedence: zero x finite -> signed zero, no flags.
REQ-033 SHALL, for every special-case result, still take the full MULT/NORM/ROUND/DONE latency; latency is data-independent.
REQ-034 SHALL drive flags = 0 for any exact normal result.

Reset
REQ-035 SHALL, while n_rst = 0, immediately force state = IDLE, in_ready = 1, out_valid = 0, result = 0, flags = 0, and clear all internal registers.
REQ-036 SHALL discard an in-flight operation when reset is asserted in any state; no stale result may appear after release.
REQ-037 SHALL allow capture on the first rising edge after n_rst deasserts.

Verification
REQ-038 SHALL cover EXP_W=5/MAN_W=10, a=0x4000, b=0x4200 -> result 0x4600, flags 0000, out_valid 3 edges after capture.
REQ-039 SHALL cover a=0x3C01, b=0x3E00 (RNE tie, odd lsb) -> result 0x3E02, flags 0001.
REQ-040 SHALL cover a=0x7BFF, b=0x4000 -> result 0x7C00, flags 0101; and a=0x7C00, b=0x0000 -> result 0x7E00, flags 1000.
REQ-041 SHALL cover a=0x0400, b=0x3800 -> result 0x0000, flags 0011; and a=0x8400, b=0x3800 -> result 0x8000, flags 0011.
REQ-042 SHALL cover out_ready held 0 for 5 cycles in DONE -> result, flags and out_valid stable and in_ready = 0; then out_ready = 1 -> IDLE next edge.
REQ-043 SHALL cover n_rst pulsed low while in NORM -> out_valid never asserts for that operation; after release, 0x3C00 x 0x3C00 -> 0x3C00, flags 0000.

Source files
------------

// File: rtl/fp_mult_param.sv
// Parameterised floating-point multiplier: multi-cycle FSM with round-to-nearest-even,
// flush-to-zero of subnormals and IEEE-style special-case handling.
module fp_mult_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int XW   = EXP_W + 2;

  localparam logic [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0] ONE_X  = XW'(1);
  localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_NORMAL  = 3'd0,
    K_QNAN    = 3'd1,
    K_INVALID = 3'd2,
    K_INF     = 3'd3,
    K_ZERO    = 3'd4
  } kind_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [PW-1:0]      r_prod;
  logic [XW-1:0]      r_exp;
  logic               r_sign;
  kind_t              r_kind;
  logic [MAN_W-1:0]   r_man;
  logic               r_guard;
  logic               r_rnd;
  logic               r_sticky;
  logic [W-1:0]       r_result;
  logic [3:0]         r_flags;

  logic [EXP_W-1:0]   w_exp_a;
  logic [EXP_W-1:0]   w_exp_b;
  logic [MAN_W-1:0]   w_man_a;
  logic [MAN_W-1:0]   w_man_b;
  logic               w_nan_a;
  logic               w_nan_b;
  logic               w_inf_a;
  logic               w_inf_b;
  logic               w_zero_a;
  logic               w_zero_b;
  kind_t              w_kind;
  logic               w_sign;
  logic [PW-1:0]      w_prod;
  logic [XW-1:0]      w_exp_sum;

  logic [MAN_W-1:0]   w_man_n;
  logic               w_guard_n;
  logic               w_rnd_n;
  logic               w_sticky_n;
  logic [XW-1:0]      w_exp_n;

  logic               w_round_up;
  logic [MAN_W:0]     w_man_inc;
  logic [MAN_W-1:0]   w_man_r;
  logic [XW-1:0]      w_exp_r;
  logic               w_inexact;
  logic [W-1:0]       w_result_r;
  logic [3:0]         w_flags_r;

  assign w_exp_a  = r_a[W-2:MAN_W];
  assign w_exp_b  = r_b[W-2:MAN_W];
  assign w_man_a  = r_a[MAN_W-1:0];
  assign w_man_b  = r_b[MAN_W-1:0];
  // Subnormal operands (exp == 0) are classified as zero.
  assign w_nan_a  = (&w_exp_a) & (|w_man_a);
  assign w_nan_b  = (&w_exp_b) & (|w_man_b);
  assign w_inf_a  = (&w_exp_a) & ~(|w_man_a);
  assign w_inf_b  = (&w_exp_b) & ~(|w_man_b);
  assign w_zero_a = ~(|w_exp_a);
  assign w_zero_b = ~(|w_exp_b);
  assign w_sign   = r_a[W-1] ^ r_b[W-1];

  assign w_prod    = PW'({1'b1, w_man_a}) * PW'({1'b1, w_man_b});
  assign w_exp_sum = {2'b00, w_exp_a} + {2'b00, w_exp_b} - BIAS_X;

  // Special-case classification in precedence order.
  always_comb begin
    w_kind = K_NORMAL;
    if (w_nan_a | w_nan_b) begin
      w_kind = K_QNAN;
    end else if ((w_inf_a & w_zero_b) | (w_zero_a & w_inf_b)) begin
      w_kind = K_INVALID;
    end else if (w_inf_a | w_inf_b) begin
      w_kind = K_INF;
    end else if (w_zero_a | w_zero_b) begin
      w_kind = K_ZERO;
    end else begin
      w_kind = K_NORMAL;
    end
  end

  // Normalisation: select mantissa, guard, round and sticky from the product.
  always_comb begin
    w_man_n    = r_prod[PW-3:MAN_W];
    w_guard_n  = r_prod[MAN_W-1];
    w_rnd_n    = r_prod[MAN_W-2];
    w_sticky_n = |r_prod[MAN_W-3:0];
    w_exp_n    = r_exp;
    if (r_prod[PW-1]) begin
      w_man_n    = r_prod[PW-2:MAN_W+1];
      w_guard_n  = r_prod[MAN_W];
      w_rnd_n    = r_prod[MAN_W-1];
      w_sticky_n = |r_prod[MAN_W-2:0];
      w_exp_n    = r_exp + ONE_X;
    end else begin
      w_exp_n    = r_exp;
    end
  end

  assign w_round_up = r_guard & (r_rnd | r_sticky | r_man[0]);
  assign w_man_inc  = {1'b0, r_man} + {{MAN_W{1'b0}}, w_round_up};
  assign w_inexact  = r_guard | r_rnd | r_sticky;

  // Rounding, renormalisation on carry-out, range checks and final result selection.
  always_comb begin
    w_man_r    = w_man_inc[MAN_W-1:0];
    w_exp_r    = r_exp;
    w_result_r = {W{1'b0}};
    w_flags_r  = 4'b0000;
    if (w_man_inc[MAN_W]) begin
      w_man_r = {MAN_W{1'b0}};
      w_exp_r = r_exp + ONE_X;
    end else begin
      w_man_r = w_man_inc[MAN_W-1:0];
      w_exp_r = r_exp;
    end
    case (r_kind)
      K_QNAN: begin
        w_result_r = QNAN;
        w_flags_r  = 4'b0000;
      end
      K_INVALID: begin
        w_result_r = QNAN;
        w_flags_r  = 4'b1000;
      end
      K_INF: begin
        w_result_r = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_flags_r  = 4'b0000;
      end
      K_ZERO: begin
        w_result_r = {r_sign, {(W-1){1'b0}}};
        w_flags_r  = 4'b0000;
      end
      K_NORMAL: begin
        if ($signed(w_exp_r) >= $signed(EMAX_X)) begin
          w_result_r = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_flags_r  = 4'b0101;
        end else if ($signed(w_exp_r) <= $signed({XW{1'b0}})) begin
          w_result_r = {r_sign, {(W-1){1'b0}}};
          w_flags_r  = 4'b0011;
        end else begin
          w_result_r = {r_sign, w_exp_r[EXP_W-1:0], w_man_r};
          w_flags_r  = {3'b000, w_inexact};
        end
      end
      default: begin
        w_result_r = {W{1'b0}};
        w_flags_r  = 4'b0000;
      end
    endcase
  end

  // Next-state logic: fixed four-cycle pipeline walk, handshakes only at IDLE and DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = MULT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MULT:  w_state_nxt = NORM;
      NORM:  w_state_nxt = ROUND;
      ROUND: w_state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Datapath registers, each stage loaded only in its own state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a      <= {W{1'b0}};
      r_b      <= {W{1'b0}};
      r_prod   <= {PW{1'b0}};
      r_exp    <= {XW{1'b0}};
      r_sign   <= 1'b0;
      r_kind   <= K_NORMAL;
      r_man    <= {MAN_W{1'b0}};
      r_guard  <= 1'b0;
      r_rnd    <= 1'b0;
      r_sticky <= 1'b0;
      r_result <= {W{1'b0}};
      r_flags  <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        MULT: begin
          r_prod <= w_prod;
          r_exp  <= w_exp_sum;
          r_sign <= w_sign;
          r_kind <= w_kind;
        end
        NORM: begin
          r_man    <= w_man_n;
          r_guard  <= w_guard_n;
          r_rnd    <= w_rnd_n;
          r_sticky <= w_sticky_n;
          r_exp    <= w_exp_n;
        end
        ROUND: begin
          r_result <= w_result_r;
          r_flags  <= w_flags_r;
        end
        DONE: begin
          r_result <= r_result;
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_mult_param.sv
// Self-checking bench for fp_mult_param: directed corner cases plus randomized traffic
// scored against an arithmetic reference model of the multiplier.
module tb_fp_mult_param;

  localparam int EW   = 5;
  localparam int MW   = 10;
  localparam int WW   = 1 + EW + MW;
  localparam int EMAX = (1 << EW) - 1;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic [WW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic          clk;
  logic          n_rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] a;
  logic [WW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] result;
  logic [3:0]    flags;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [WW+3:0] expv;
    int            cap;
  } entry_t;
  entry_t q[$];
  entry_t ent;

  fp_mult_param #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: exact integer product rounded to MW+1 significant bits by remainder comparison.
  function automatic logic [WW+3:0] ref_mul(input logic [WW-1:0] x, input logic [WW-1:0] y);
    int ex, ey, e, sh;
    longint mx, my, p, qv, rem, half;
    bit s, nx, ny, ix, iy, zx, zy, inx;
    logic [WW-1:0] r;
    logic [3:0] f;
    ex = int'(x[WW-2:MW]);  mx = longint'(x[MW-1:0]);
    ey = int'(y[WW-2:MW]);  my = longint'(y[MW-1:0]);
    nx = (ex == EMAX) && (mx != 0);  ix = (ex == EMAX) && (mx == 0);  zx = (ex == 0);
    ny = (ey == EMAX) && (my != 0);  iy = (ey == EMAX) && (my == 0);  zy = (ey == 0);
    s = x[WW-1] ^ y[WW-1];
    f = 4'b0000;
    if (nx || ny) begin
      r = QNAN;
    end else if ((ix && zy) || (zx && iy)) begin
      r = QNAN;
      f = 4'b1000;
    end else if (ix || iy) begin
      r = {s, {EW{1'b1}}, {MW{1'b0}}};
    end else if (zx || zy) begin
      r = {s, {(WW-1){1'b0}}};
    end else begin
      p  = ((longint'(1) << MW) + mx) * ((longint'(1) << MW) + my);
      e  = ex + ey - BIAS;
      sh = MW;
      if (p >= (longint'(1) << (2*MW + 1))) begin
        sh = MW + 1;
        e++;
      end
      qv   = p >> sh;
      rem  = p - (qv << sh);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && qv[0] == 1'b1)) qv++;
      if (qv == (longint'(1) << (MW + 1))) begin
        qv = qv >> 1;
        e++;
      end
      if (e >= EMAX) begin
        r = {s, {EW{1'b1}}, {MW{1'b0}}};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, {(WW-1){1'b0}}};
        f = 4'b0011;
      end else begin
        r = {s, e[EW-1:0], qv[MW-1:0]};
        f = {3'b000, inx};
      end
    end
    return {f, r};
  endfunction

  function automatic logic [WW-1:0] rand_op();
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    int            k;
    s = 1'($urandom_range(0, 1));
    m = MW'($urandom);
    e = EW'($urandom_range(1, EMAX - 1));
    k = $urandom_range(0, 11);
    case (k)
      0: begin e = {EW{1'b0}}; m = {MW{1'b0}}; end
      1: e = {EW{1'b0}};
      2: begin e = {EW{1'b1}}; m = {MW{1'b0}}; end
      3: begin e = {EW{1'b1}}; m[0] = 1'b1; end
      4: e = EW'($urandom_range(EMAX - 5, EMAX - 1));
      5: e = EW'($urandom_range(1, 5));
      6: m = {m[MW-1:MW-3], {(MW-3){1'b0}}};
      default: e = EW'($urandom_range(1, EMAX - 1));
    endcase
    return {s, e, m};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!n_rst) begin
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      q.delete();
    end else begin
      check("in_ready", 32'(in_ready), 32'(q.size() == 0));
      if (q.size() == 0) begin
        check("no_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_valid", 32'(out_valid), 32'(cyc >= q[0].cap + 3));
        if (out_valid) begin
          check("result", 32'(result), 32'(q[0].expv[WW-1:0]));
          check("flags", 32'(flags), 32'(q[0].expv[WW+3:WW]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        ent.expv = ref_mul(a, b);
        ent.cap  = cyc + 1;
        q.push_back(ent);
      end
    end
  end

  // Directed operation; entered and left at #1 after a rising edge with the DUT idle.
  task automatic do_op(input logic [WW-1:0] x, input logic [WW-1:0] y,
                       input logic [WW-1:0] er, input logic [3:0] ef, input int hold);
    int n;
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("d_latency", 32'(n), 32'd3);
    check("d_result", 32'(result), 32'(er));
    check("d_flags", 32'(flags), 32'(ef));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      check("hold_result", 32'(result), 32'(er));
      check("hold_flags", 32'(flags), 32'(ef));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("back_idle_ready", 32'(in_ready), 32'd1);
    check("back_idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    n_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = {WW{1'b0}};
    b = {WW{1'b0}};

    // Hand-computed values that pin the reference model.
    check("pin_basic", 32'(ref_mul(16'h4000, 16'h4200)), 32'({4'b0000, 16'h4600}));
    check("pin_tie", 32'(ref_mul(16'h3C01, 16'h3E00)), 32'({4'b0001, 16'h3E02}));
    check("pin_ovf", 32'(ref_mul(16'h7BFF, 16'h4000)), 32'({4'b0101, 16'h7C00}));
    check("pin_inv", 32'(ref_mul(16'h7C00, 16'h0000)), 32'({4'b1000, 16'h7E00}));
    check("pin_unf", 32'(ref_mul(16'h8400, 16'h3800)), 32'({4'b0011, 16'h8000}));
    check("pin_nan", 32'(ref_mul(16'h7C01, 16'hFC00)), 32'({4'b0000, 16'h7E00}));
    check("pin_inf", 32'(ref_mul(16'hFC00, 16'h3C00)), 32'({4'b0000, 16'hFC00}));
    check("pin_sub", 32'(ref_mul(16'h0001, 16'hBC00)), 32'({4'b0000, 16'h8000}));

    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    // Capture on the first edge after reset release.
    do_op(16'h4000, 16'h4200, 16'h4600, 4'b0000, 0);
    do_op(16'h3C01, 16'h3E00, 16'h3E02, 4'b0001, 0);
    do_op(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101, 0);
    do_op(16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 5);
    do_op(16'h0400, 16'h3800, 16'h0000, 4'b0011, 0);
    do_op(16'h8400, 16'h3800, 16'h8000, 4'b0011, 0);
    do_op(16'h7C01, 16'hFC00, 16'h7E00, 4'b0000, 0);

    // Kill an operation in NORM; it must never produce a result.
    a = 16'h4000;
    b = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    do_op(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 0);

    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rand_op();
      b         = rand_op();
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
